fp16_max_reduce: RTL

Streaming FP16 max-reduction sequencer for the softmax front end. It accepts one FP16 element per cycle over an AXI-Stream-style input. Vectors are delimited by `s_tlast`. For each vector it emits the maximum value, the index of that maximum and the element count. It owns the pairwise compare/select resource and schedules one compare per accepted element, so no external comparator handshake is needed.

---
 rtl/fp16_pkg.sv | 24 ++
 rtl/fp16_max_reduce_if.sv | 30 +++
 rtl/fp16_gt.sv | 12 +
 rtl/fp16_max_reduce.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants, classification/ordering helpers and the reducer FSM state type.
package fp16_pkg;

    localparam int unsigned FP16_W    = 16;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    function automatic logic fp16_isnan(input logic [FP16_W-1:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // Monotonic unsigned key: -0 folds onto +0, negatives invert so larger magnitude sorts lower.
    function automatic logic [FP16_W-1:0] fp16_key(input logic [FP16_W-1:0] x);
        logic [FP16_W-1:0] z;
        z = (x == 16'h8000) ? '0 : x;
        return z[15] ? ~z : (z | 16'h8000);
    endfunction

endpackage

// File: rtl/fp16_max_reduce_if.sv
// Stream-in / result-out bundle for the FP16 max reducer.
interface fp16_max_reduce_if #(
    parameter int unsigned IDX_W = 10
);
    import fp16_pkg::*;

    logic              s_tvalid;
    logic              s_tready;
    logic [FP16_W-1:0] s_tdata;
    logic              s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [FP16_W-1:0] m_tdata;
    logic [IDX_W-1:0]  m_tindex;
    logic [IDX_W:0]    m_tcount;
    logic              m_tnan;
    logic              m_tlen_err;

    // slave: the reducer itself; master: the producer/consumer environment around it.
    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tindex, m_tcount, m_tnan, m_tlen_err
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tindex, m_tcount, m_tnan, m_tlen_err
    );

endinterface

// File: rtl/fp16_gt.sv
// Combinational strict greater-than on FP16 values using the ordered key.
module fp16_gt
    import fp16_pkg::*;
(
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic              a_gt_b
);

    assign a_gt_b = fp16_key(a) > fp16_key(b);

endmodule

// File: rtl/fp16_max_reduce.sv
// Streaming FP16 max reduction: per vector emits max (or qNaN), its index and element count.
module fp16_max_reduce
    import fp16_pkg::*;
#(
    parameter int unsigned IDX_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    fp16_max_reduce_if.slave bus
);

    localparam logic [IDX_W:0] LastCnt = {1'b0, {IDX_W{1'b1}}};
    localparam logic [IDX_W:0] OneCnt  = {{IDX_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [FP16_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic              nan_q, nan_d;

    logic [FP16_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [IDX_W:0]    out_cnt_q, out_cnt_d;
    logic              out_nan_q, out_nan_d;
    logic              out_len_err_q, out_len_err_d;

    logic              accept;
    logic              in_nan;
    logic              in_gt;
    logic              implicit_last;
    logic              is_last;
    logic [FP16_W-1:0] acc_max;
    logic [IDX_W-1:0]  acc_idx;
    logic [IDX_W:0]    acc_cnt;
    logic              acc_nan;

    fp16_gt u_gt (
        .a      (bus.s_tdata),
        .b      (max_q),
        .a_gt_b (in_gt)
    );

    // Running state after folding in the element currently on the bus.
    always_comb begin
        accept        = bus.s_tvalid && (state_q != StHold);
        in_nan        = fp16_isnan(bus.s_tdata);
        implicit_last = (cnt_q == LastCnt);
        is_last       = bus.s_tlast || implicit_last;
        acc_max       = max_q;
        acc_idx       = idx_q;
        acc_cnt       = cnt_q + OneCnt;
        acc_nan       = nan_q;
        if (state_q == StIdle) begin
            acc_max = bus.s_tdata;
            acc_idx = '0;
            acc_cnt = OneCnt;
            acc_nan = in_nan;
        end else if (!nan_q && in_nan) begin
            acc_nan = 1'b1;
            acc_idx = cnt_q[IDX_W-1:0];
        end else if (!nan_q && in_gt) begin
            acc_max = bus.s_tdata;
            acc_idx = cnt_q[IDX_W-1:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        max_d         = max_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        nan_d         = nan_q;
        out_data_d    = out_data_q;
        out_idx_d     = out_idx_q;
        out_cnt_d     = out_cnt_q;
        out_nan_d     = out_nan_q;
        out_len_err_d = out_len_err_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    max_d = acc_max;
                    idx_d = acc_idx;
                    cnt_d = acc_cnt;
                    nan_d = acc_nan;
                    if (is_last) begin
                        state_d       = StHold;
                        out_data_d    = acc_nan ? FP16_QNAN : acc_max;
                        out_idx_d     = acc_idx;
                        out_cnt_d     = acc_cnt;
                        out_nan_d     = acc_nan;
                        out_len_err_d = implicit_last && !bus.s_tlast;
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StHold: begin
                if (bus.m_tready) begin
                    state_d = StIdle;
                    max_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    nan_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            max_q         <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            nan_q         <= 1'b0;
            out_data_q    <= '0;
            out_idx_q     <= '0;
            out_cnt_q     <= '0;
            out_nan_q     <= 1'b0;
            out_len_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            max_q         <= max_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            nan_q         <= nan_d;
            out_data_q    <= out_data_d;
            out_idx_q     <= out_idx_d;
            out_cnt_q     <= out_cnt_d;
            out_nan_q     <= out_nan_d;
            out_len_err_q <= out_len_err_d;
        end
    end

    assign bus.s_tready   = (state_q != StHold);
    assign bus.m_tvalid   = (state_q == StHold);
    assign bus.m_tdata    = out_data_q;
    assign bus.m_tindex   = out_idx_q;
    assign bus.m_tcount   = out_cnt_q;
    assign bus.m_tnan     = out_nan_q;
    assign bus.m_tlen_err = out_len_err_q;

endmodule
